// File: rtl/fm_pkg.sv
// Shared types, widths and helpers for the FM phase-increment generator.
package fm_pkg;

    localparam int unsigned AUDIO_W = 16;
    localparam int unsigned PHASE_W = 32;
    localparam int unsigned GAIN_W  = 16;

    typedef logic signed [AUDIO_W-1:0] audio_t;
    typedef logic        [PHASE_W-1:0] phase_t;

    typedef logic state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t RUN  = 1'b1;

    function automatic audio_t sat16(input logic signed [17:0] v);
        if (v > 18'sd32767) begin
            return audio_t'(16'h7fff);
        end else if (v < -18'sd32768) begin
            return audio_t'(16'h8000);
        end else begin
            return audio_t'(v[15:0]);
        end
    endfunction

endpackage

// File: rtl/fm_phaseinc_gen_if.sv
// Audio sample valid/ready stream into the FM phase-increment generator.
interface fm_phaseinc_gen_if;
    import fm_pkg::*;

    audio_t audio_in;
    logic   audio_valid;
    logic   audio_ready;

    modport master (output audio_in, output audio_valid, input audio_ready);
    modport slave  (input audio_in, input audio_valid, output audio_ready);

endinterface

// File: rtl/fm_interp.sv
// One-entry sample buffer plus linear interpolator advancing on enableclk.
// FM_PREEMPH_EN adds first-order pre-emphasis on the accept path.
module fm_interp
    import fm_pkg::*;
#(
    parameter int unsigned INTERP_LOG2 = 4
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   enableclk,
    input  audio_t audio_in,
    input  logic   audio_valid,
    output logic   audio_ready,
    output audio_t interp,
    output logic   underrun
);

    localparam int unsigned ACC_W = 17 + INTERP_LOG2;

    state_t                   state_q, state_d;
    audio_t                   prev_q, prev_d, cur_q, cur_d, next_q, next_d, wr_data;
    logic                     next_full_q, next_full_d, ready_q, underrun_q, underrun_d;
    logic                     accept, consume;
    logic [INTERP_LOG2-1:0]   step_q, step_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [16:0]       delta;

    assign accept = audio_valid && ready_q;
    assign delta  = $signed({cur_q[15], cur_q}) - $signed({prev_q[15], prev_q});

`ifdef FM_PREEMPH_EN
    audio_t             x_last_q;
    logic signed [17:0] emph;

    assign emph    = (18'(audio_in) <<< 1) - 18'(x_last_q);
    assign wr_data = sat16(emph);

    always_ff @(posedge clock) begin
        if (reset) begin
            x_last_q <= '0;
        end else if (accept) begin
            x_last_q <= audio_in;
        end
    end
`else
    assign wr_data = audio_in;
`endif

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        cur_d      = cur_q;
        step_d     = step_q;
        acc_d      = acc_q;
        underrun_d = 1'b0;
        consume    = 1'b0;
        if (enableclk) begin
            case (state_q)
                IDLE: begin
                    if (next_full_q) begin
                        state_d = RUN;
                        prev_d  = '0;
                        cur_d   = next_q;
                        consume = 1'b1;
                        acc_d   = '0;
                        step_d  = '0;
                    end
                end
                default: begin
                    if (step_q == '1) begin
                        // Segment end: snap acc to cur exactly so rounding never accumulates.
                        step_d = '0;
                        acc_d  = ACC_W'(cur_q) <<< INTERP_LOG2;
                        prev_d = cur_q;
                        if (next_full_q) begin
                            cur_d   = next_q;
                            consume = 1'b1;
                        end else begin
                            underrun_d = 1'b1;
                        end
                    end else begin
                        acc_d  = acc_q + ACC_W'(delta);
                        step_d = step_q + 1'b1;
                    end
                end
            endcase
        end
        // Consume first, then fill: a same-clock transfer lands in the freed slot.
        next_full_d = (next_full_q && !consume) || accept;
        next_d      = accept ? wr_data : next_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            prev_q      <= '0;
            cur_q       <= '0;
            next_q      <= '0;
            next_full_q <= 1'b0;
            ready_q     <= 1'b0;
            step_q      <= '0;
            acc_q       <= '0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            cur_q       <= cur_d;
            next_q      <= next_d;
            next_full_q <= next_full_d;
            ready_q     <= !next_full_d;
            step_q      <= step_d;
            acc_q       <= acc_d;
            underrun_q  <= underrun_d;
        end
    end

    assign audio_ready = ready_q;
    assign underrun    = underrun_q;
    assign interp      = sat16(18'(acc_q >>> INTERP_LOG2));

endmodule

// File: rtl/fm_phaseinc_gen.sv
// FM phase-increment generator: interpolated audio x deviation gain + carrier.
// Optional pre-emphasis is enabled with the FM_PREEMPH_EN macro (see fm_interp).
module fm_phaseinc_gen
    import fm_pkg::*;
#(
    parameter int unsigned INTERP_LOG2 = 4,
    parameter int unsigned GAIN_SHIFT  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enableclk,
    fm_phaseinc_gen_if.slave  audio,
    input  phase_t            carrier_inc,
    input  logic [GAIN_W-1:0] dev_gain,
    output phase_t            phaseinc,
    output logic              underrun
);

    audio_t             interp, s1_q;
    logic signed [32:0] s1_ext, gain_ext, prod_d, s2_q, scaled;
    phase_t             phaseinc_q, phaseinc_d;

    fm_interp #(
        .INTERP_LOG2 (INTERP_LOG2)
    ) u_interp (
        .clock       (clock),
        .reset       (reset),
        .enableclk   (enableclk),
        .audio_in    (audio.audio_in),
        .audio_valid (audio.audio_valid),
        .audio_ready (audio.audio_ready),
        .interp      (interp),
        .underrun    (underrun)
    );

    // Gain is unsigned, so it is zero-extended before the signed multiply.
    assign s1_ext     = 33'(s1_q);
    assign gain_ext   = $signed({17'b0, dev_gain});
    assign prod_d     = s1_ext * gain_ext;
    assign scaled     = s2_q >>> GAIN_SHIFT;
    assign phaseinc_d = carrier_inc + PHASE_W'(scaled);

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            phaseinc_q <= '0;
        end else begin
            s1_q       <= interp;
            s2_q       <= prod_d;
            phaseinc_q <= phaseinc_d;
        end
    end

    assign phaseinc = phaseinc_q;

endmodule

// File: tb/tb_fm_phaseinc_gen.sv
// Bench for fm_phaseinc_gen: directed tables/sequences plus random stimulus vs a sample-level model.
module tb_fm_phaseinc_gen;
    import fm_pkg::*;

    localparam int L2 = 2;
    localparam int L  = 4;

    logic        clock = 1'b0;
    logic        reset, enableclk;
    phase_t      carrier_inc;
    logic [15:0] dev_gain;
    phase_t      ph_a, ph_b;
    logic        un_a, un_b;

    fm_phaseinc_gen_if bus_a ();
    fm_phaseinc_gen_if bus_b ();

    always #5 clock = ~clock;

    fm_phaseinc_gen #(.INTERP_LOG2(L2), .GAIN_SHIFT(0)) dut_a (
        .clock(clock), .reset(reset), .enableclk(enableclk), .audio(bus_a),
        .carrier_inc(carrier_inc), .dev_gain(dev_gain), .phaseinc(ph_a), .underrun(un_a)
    );

    fm_phaseinc_gen #(.INTERP_LOG2(L2), .GAIN_SHIFT(8)) dut_b (
        .clock(clock), .reset(reset), .enableclk(enableclk), .audio(bus_b),
        .carrier_inc(carrier_inc), .dev_gain(dev_gain), .phaseinc(ph_b), .underrun(un_b)
    );

    int checks = 0;
    int errors = 0;

    // Sample-level reference: segment endpoints p/c, tick index j, one-entry queue.
    bit          m_run = 0, m_has = 0, m_ready = 0, m_acc = 0, exp_un = 0;
    int          m_p = 0, m_c = 0, m_j = 0, m_nxt = 0, m_xlast = 0;
    int          ih1 = 0, ih2 = 0, ih3 = 0, g1 = 0;
    logic [31:0] exp_a = 0, exp_b = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fdiv(input int num);
        int q;
        q = num / L;
        if ((num % L) != 0 && num < 0) q = q - 1;
        return q;
    endfunction

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic logic [31:0] scale(input int i, input int g, input int gs);
        longint pr;
        pr = longint'(i) * longint'(g);
        pr = pr >>> gs;
        return pr[31:0];
    endfunction

    task automatic step(input logic rst, input logic en, input logic vld,
                        input logic signed [15:0] d, input logic [31:0] car,
                        input logic [15:0] g);
        int ival;
        reset = rst;
        enableclk = en;
        bus_a.audio_valid = vld;
        bus_b.audio_valid = vld;
        bus_a.audio_in = d;
        bus_b.audio_in = d;
        carrier_inc = car;
        dev_gain = g;
        @(posedge clock);
        exp_a = rst ? 32'h0 : car + scale(ih3, g1, 0);
        exp_b = rst ? 32'h0 : car + scale(ih3, g1, 8);
        exp_un = 0;
        m_acc = 0;
        if (rst) begin
            m_run = 0; m_has = 0; m_p = 0; m_c = 0; m_j = 0; m_nxt = 0; m_xlast = 0;
            m_ready = 0; ih1 = 0; ih2 = 0; ih3 = 0;
        end else begin
            m_acc = vld && m_ready;
            if (en) begin
                if (!m_run) begin
                    if (m_has) begin
                        m_run = 1; m_p = 0; m_c = m_nxt; m_j = 0; m_has = 0;
                    end
                end else if (m_j == L - 1) begin
                    m_j = 0;
                    m_p = m_c;
                    if (m_has) begin
                        m_c = m_nxt; m_has = 0;
                    end else begin
                        exp_un = 1;
                    end
                end else begin
                    m_j++;
                end
            end
            if (m_acc) begin
`ifdef FM_PREEMPH_EN
                m_nxt = sat(2 * int'(d) - m_xlast);
                m_xlast = int'(d);
`else
                m_nxt = int'(d);
`endif
                m_has = 1;
            end
            m_ready = !m_has;
            ival = m_run ? sat(fdiv(m_p * L + m_j * (m_c - m_p))) : 0;
            ih3 = ih2; ih2 = ih1; ih1 = ival;
        end
        g1 = int'(g);
        @(negedge clock);
        check("phaseinc_a", 64'(ph_a), 64'(exp_a));
        check("phaseinc_b", 64'(ph_b), 64'(exp_b));
        check("underrun_a", 64'(un_a), 64'(exp_un));
        check("underrun_b", 64'(un_b), 64'(exp_un));
        check("ready_a", 64'(bus_a.audio_ready), 64'(m_ready));
        check("ready_b", 64'(bus_b.audio_ready), 64'(m_ready));
    endtask

    // Offer x until accepted, then keep ticking until the output is flat at the stored value.
    task automatic feed_and_settle(input logic signed [15:0] x, input logic [31:0] car,
                                   input logic [15:0] g);
        bit done;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            step(1'b0, 1'b1, 1'b1, x, car, g);
            done = m_acc;
        end
        check("feed_accepted", 64'(done), 64'd1);
        for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1'b0, 16'sd0, car, g);
    endtask

    typedef struct {
        logic signed [15:0] x;
        logic [15:0]        g;
        logic [31:0]        car;
        logic [31:0]        exp_a;
        logic [31:0]        exp_b;
    } vec_t;

    vec_t tbl[6];
    int   seen[$];
    int   cnt;

    initial begin
        tbl[0] = '{x: -16'sd32768, g: 16'hFFFF, car: 32'h0000_0010,
                   exp_a: 32'h8000_8010, exp_b: 32'hFF80_0090};
        tbl[1] = '{x: 16'sd400, g: 16'd1, car: 32'h0, exp_a: 32'h0000_0190, exp_b: 32'h1};
        tbl[2] = '{x: 16'sd1000, g: 16'd256, car: 32'h0100_0000,
                   exp_a: 32'h0103_E800, exp_b: 32'h0100_03E8};
        tbl[3] = '{x: -16'sd1, g: 16'd1, car: 32'h5, exp_a: 32'h4, exp_b: 32'h4};
        tbl[4] = '{x: 16'sd32767, g: 16'hFFFF, car: 32'hFFFF_FFF0,
                   exp_a: 32'h7FFE_7FF1, exp_b: 32'h007F_FE70};
        tbl[5] = '{x: -16'sd300, g: 16'd3, car: 32'h0, exp_a: 32'hFFFF_FC7C, exp_b: 32'hFFFF_FFFC};

        reset = 1'b1; enableclk = 1'b0; carrier_inc = '0; dev_gain = '0;
        bus_a.audio_valid = 1'b0; bus_b.audio_valid = 1'b0;
        bus_a.audio_in = '0; bus_b.audio_in = '0;
        @(negedge clock);

        // Reset and idle carrier.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 16'sd0, 32'h0100_0000, 16'd0);
            check("reset_phaseinc", 64'(ph_a), 64'd0);
            check("reset_ready", 64'(bus_a.audio_ready), 64'd0);
        end
        cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'sd0, 32'h0100_0000, 16'd0);
            if (un_a) cnt++;
            if (i >= 3) check("idle_carrier", 64'(ph_a), 64'h0100_0000);
        end
        check("idle_no_underrun", 64'(cnt), 64'd0);

        // Ramp 400 -> 800 with L=4, then held flat with one underrun per segment.
        step(1'b1, 1'b1, 1'b0, 16'sd0, 32'h0, 16'd1);
        seen.delete();
        cnt = 0;
        for (int i = 1; i <= 24; i++) begin
            logic signed [15:0] d;
            d = (m_has || m_run || m_c != 0) ? 16'sd800 : 16'sd400;
            step(1'b0, 1'b1, (i <= 4), d, 32'h0, 16'd1);
            if (un_a) cnt++;
            if (seen.size() == 0 || seen[$] != int'(ph_a)) seen.push_back(int'(ph_a));
        end
        check("ramp_len", 64'(seen.size()), 64'd9);
        for (int i = 0; i < 9 && i < seen.size(); i++) check("ramp_value", 64'(seen[i]), 64'(i * 100));
        check("ramp_underruns", 64'(cnt), 64'd4);

        // Gain/shift/carrier arithmetic table; feeding x twice stores x even with pre-emphasis.
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0, 1'b0, 16'sd0, tbl[k].car, tbl[k].g);
            feed_and_settle(tbl[k].x, tbl[k].car, tbl[k].g);
            feed_and_settle(tbl[k].x, tbl[k].car, tbl[k].g);
            check("table_a", 64'(ph_a), 64'(tbl[k].exp_a));
            check("table_b", 64'(ph_b), 64'(tbl[k].exp_b));
        end

        // Valid held with enableclk low: one accept, ready stays low, nothing advances.
        step(1'b1, 1'b0, 1'b0, 16'sd0, 32'h77, 16'd1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b1, 16'sd1234, 32'h77, 16'd1);
            if (bus_a.audio_ready) cnt++;
        end
        check("held_ready_cycles", 64'(cnt), 64'd1);
        check("held_no_advance", 64'(ph_a), 64'h77);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 16'sd1234, 32'h77, 16'd1);
        step(1'b1, 1'b1, 1'b1, 16'sd1234, 32'h77, 16'd1);
        check("midreset_phaseinc", 64'(ph_a), 64'd0);
        check("midreset_ready", 64'(bus_a.audio_ready), 64'd0);
        check("midreset_underrun", 64'(un_a), 64'd0);

`ifdef FM_PREEMPH_EN
        step(1'b1, 1'b0, 1'b0, 16'sd0, 32'h0, 16'd1);
        feed_and_settle(16'sd1000, 32'h0, 16'd1);
        check("preemph_first", 64'(ph_a), 64'd2000);
        feed_and_settle(16'sd1000, 32'h0, 16'd1);
        check("preemph_second", 64'(ph_a), 64'd1000);
        feed_and_settle(16'sd30000, 32'h0, 16'd1);
        check("preemph_sat", 64'(ph_a), 64'd32767);
`endif

        // Random traffic against the model.
        step(1'b1, 1'b0, 1'b0, 16'sd0, 32'h0, 16'd0);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0), 16'($urandom), $urandom, 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
